// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Byte 0 of every 128-bit word sits in bits [127:120] (FIPS-197 column-major order).
module aes_top (
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         AES_en,
   input  logic [127:0] AES_data_in,
   input  logic [127:0] AES_key_in,
   output logic [127:0] AES_data_out,
   output logic         AES_data_out_valid
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] round);
      case (round)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [0:0]   fsm_state;
   logic [127:0] state_reg;
   logic [127:0] round_key;
   logic [3:0]   round_cnt;

   logic [127:0] sub_bytes;
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [127:0] next_key;
   logic [31:0]  key_rot;
   logic [31:0]  key_sub;
   logic [31:0]  key_temp;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub
         assign sub_bytes[127-8*gi -: 8] = SBOX[state_reg[127-8*gi -: 8]];
      end
      for (gi = 0; gi < 4; gi++) begin : g_key_sub
         assign key_sub[31-8*gi -: 8] = SBOX[key_rot[31-8*gi -: 8]];
      end
   endgenerate

   // Row r of column c takes the byte from column (c+r) mod 4, then each column is mixed.
   always_comb begin
      shifted = '0;
      mixed   = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
      end
   end

   // Next round key derived from the stored one, using the current round's Rcon.
   assign key_rot  = {round_key[23:0], round_key[31:24]};
   assign key_temp = key_sub ^ {rcon(round_cnt), 24'h0};
   always_comb begin
      next_key[127:96] = round_key[127:96] ^ key_temp;
      next_key[95:64]  = round_key[95:64]  ^ next_key[127:96];
      next_key[63:32]  = round_key[63:32]  ^ next_key[95:64];
      next_key[31:0]   = round_key[31:0]   ^ next_key[63:32];
   end

   // Capture in IDLE, nine full rounds, then a final round without MixColumns.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         fsm_state          <= IDLE;
         state_reg          <= '0;
         round_key          <= '0;
         round_cnt          <= '0;
         AES_data_out       <= '0;
         AES_data_out_valid <= 1'b0;
      end else begin
         AES_data_out_valid <= 1'b0;
         if (fsm_state == IDLE) begin
            if (AES_en) begin
               state_reg <= AES_data_in ^ AES_key_in;
               round_key <= AES_key_in;
               round_cnt <= 4'd1;
               fsm_state <= BUSY;
            end
         end else begin
            round_key <= next_key;
            if (round_cnt == 4'd10) begin
               AES_data_out       <= shifted ^ next_key;
               AES_data_out_valid <= 1'b1;
               round_cnt          <= 4'd0;
               fsm_state          <= IDLE;
            end else begin
               state_reg <= mixed ^ next_key;
               round_cnt <= round_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_top.sv
// Directed self-checking bench for aes_top using FIPS-197 known-answer vectors.
module tb_aes_top;

   logic         AES_clk;
   logic         AES_rst_n;
   logic         AES_en;
   logic [127:0] AES_data_in;
   logic [127:0] AES_key_in;
   logic [127:0] AES_data_out;
   logic         AES_data_out_valid;

   int tests_run;
   int tests_failed;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_top dut (
      .AES_clk            (AES_clk),
      .AES_rst_n          (AES_rst_n),
      .AES_en             (AES_en),
      .AES_data_in        (AES_data_in),
      .AES_key_in         (AES_key_in),
      .AES_data_out       (AES_data_out),
      .AES_data_out_valid (AES_data_out_valid)
   );

   initial AES_clk = 1'b0;
   always #5 AES_clk = ~AES_clk;

   task automatic checkOutput(input string tag, input logic [128:0] observed, input logic [128:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [127:0] randomBlock();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Start one encryption; en stays high for holdEn edges after capture, operands may be scrambled.
   task automatic applyStimulus(input string tag, input logic [127:0] key, input logic [127:0] pt,
                                input logic [127:0] expected, input int holdEn, input bit scramble);
      int latency;
      int pulses;
      logic [127:0] got;
      latency = -1;
      pulses  = 0;
      got     = '0;
      @(negedge AES_clk);
      AES_key_in  = key;
      AES_data_in = pt;
      AES_en      = 1'b1;
      @(posedge AES_clk);
      #1;
      for (int i = 1; i <= 14; i++) begin
         if (i > holdEn) AES_en = 1'b0;
         if (scramble && i == 3) begin
            AES_data_in = randomBlock();
            AES_key_in  = randomBlock();
         end
         @(posedge AES_clk);
         #1;
         if (AES_data_out_valid) begin
            pulses++;
            if (latency < 0) begin
               latency = i;
               got     = AES_data_out;
            end
         end
      end
      checkOutput({tag, "_latency"}, 129'(latency), 129'(10));
      checkOutput({tag, "_pulses"}, 129'(pulses), 129'(1));
      checkOutput({tag, "_data"}, {1'b0, got}, {1'b0, expected});
      checkOutput({tag, "_held"}, {AES_data_out_valid, AES_data_out}, {1'b0, expected});
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      AES_rst_n    = 1'b0;
      AES_en       = 1'b0;
      AES_data_in  = '0;
      AES_key_in   = '0;

      // Reset held: inputs and enable wiggle, outputs must stay cleared.
      for (int i = 0; i < 8; i++) begin
         @(negedge AES_clk);
         AES_en      = i[0];
         AES_data_in = randomBlock();
         AES_key_in  = randomBlock();
         @(posedge AES_clk);
         #1;
         checkOutput("reset_hold", {AES_data_out_valid, AES_data_out}, 129'h0);
      end
      @(negedge AES_clk);
      AES_en    = 1'b0;
      AES_rst_n = 1'b1;

      applyStimulus("fips_c1", KEY_C1, PT_C1, CT_C1, 0, 1'b0);
      applyStimulus("fips_b_busy_changes", KEY_B, PT_B, CT_B, 5, 1'b1);

      // Continuous enable over edges 0..50: captures at 0,11,22,33,44, pulses at 10,21,32,43,54.
      @(negedge AES_clk);
      AES_key_in  = '0;
      AES_data_in = '0;
      AES_en      = 1'b1;
      @(posedge AES_clk);
      #1;
      for (int i = 1; i <= 80; i++) begin
         @(posedge AES_clk);
         #1;
         if (i == 50) AES_en = 1'b0;
         checkOutput("cont_valid", {128'h0, AES_data_out_valid},
                     {128'h0, (i % 11 == 10) && (i <= 54)});
         if (AES_data_out_valid) checkOutput("cont_data", {1'b0, AES_data_out}, {1'b0, CT_Z});
      end
      checkOutput("cont_held", {AES_data_out_valid, AES_data_out}, {1'b0, CT_Z});

      // Reset asserted at round 5 aborts the operation.
      @(negedge AES_clk);
      AES_key_in  = KEY_C1;
      AES_data_in = PT_C1;
      AES_en      = 1'b1;
      @(posedge AES_clk);
      #1;
      AES_en = 1'b0;
      repeat (5) @(posedge AES_clk);
      #1;
      AES_rst_n = 1'b0;
      #1;
      checkOutput("midreset_async", {AES_data_out_valid, AES_data_out}, 129'h0);
      repeat (2) @(posedge AES_clk);
      @(negedge AES_clk);
      AES_rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge AES_clk);
         #1;
         checkOutput("midreset_quiet", {AES_data_out_valid, AES_data_out}, 129'h0);
      end
      applyStimulus("midreset_restart", KEY_C1, PT_C1, CT_C1, 0, 1'b0);

      // Idle with random operands: no pulse, output frozen at the last result.
      for (int i = 0; i < 100; i++) begin
         @(negedge AES_clk);
         AES_en      = 1'b0;
         AES_data_in = randomBlock();
         AES_key_in  = randomBlock();
         @(posedge AES_clk);
         #1;
         checkOutput("idle_stable", {AES_data_out_valid, AES_data_out}, {1'b0, CT_C1});
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- Iterative AES-128 encryption core (FIPS-197), one round per clock, with on-the-fly key expansion.
- Top-level crypto block. Accepts a 128-bit plaintext and a 128-bit key on a start strobe.
- Returns the 128-bit ciphertext with a one-cycle valid pulse.
- Encryption only; no decryption path.

Parameters:
- none (AES-128 fixed: Nk=4, Nr=10).

Ports:
- AES_clk  input  1  system clock; all state updates on the rising edge.
- AES_rst_n  input  1  reset; asynchronous, active-low.
- AES_en  input  1  start/enable; sampled only while the core is idle.
- AES_data_in  input  128  plaintext; bits [127:120] = byte 0 (FIPS-197 column-major input order).
- AES_key_in  input  128  cipher key, same byte order.
- AES_data_out  output  128  ciphertext, same byte order; holds its last value.
- AES_data_out_valid  output  1  one-cycle pulse marking a new AES_data_out.

Interface (already decided): one clock; reset is asynchronous and active-low (AES_clk, AES_rst_n).

Behaviour:
- Reset (AES_rst_n=0, asynchronous) clears the following:
  - state register, round key register and round counter to 0;
  - busy flag to 0;
  - AES_data_out to 128'h0;
  - AES_data_out_valid to 0.
- Two states: IDLE and BUSY.
- IDLE, at an edge with AES_en=1:
  - state <= AES_data_in ^ AES_key_in (initial AddRoundKey);
  - round key <= AES_key_in;
  - round counter <= 1;
  - go to BUSY.
  - This is the capture edge (edge 0).
- BUSY, round r = 1..9, one per edge:
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ RK_r.
  - RK_r comes from the stored RK_{r-1} using the standard schedule: RotWord, SubWord, Rcon.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- BUSY, round 10 (edge 10):
  - AES_data_out <= ShiftRows(SubBytes(state)) ^ RK_10 (no MixColumns);
  - AES_data_out_valid <= 1;
  - return to IDLE.
- Latency: valid is high during the cycle after edge 10, i.e. 10 cycles after the capture edge.
  - Throughput: one block per 11 cycles.
- AES_data_out_valid drops to 0 on the next edge and stays 0 outside that single cycle.
- AES_data_out holds its value until the next completion or reset.
- Back-to-back operation: AES_en is evaluated only in IDLE. If AES_en is still 1 on the edge after completion (the edge where valid is high), a new encryption captures the current inputs on that edge.
  - Continuous AES_en=1 gives a result every 11 cycles.
- AES_en deasserted mid-operation: ignored; the operation completes normally.
- AES_data_in / AES_key_in changing while BUSY: ignored; operands were latched at capture.
- Reset mid-operation: aborts immediately; no valid pulse; AES_data_out is 0.
- S-box: exact FIPS-197 S-box. It may be a ROM/case table or GF(2^8) inversion plus affine transform, but it must be combinational.
  - Resources: 16 datapath plus 4 key-schedule instances.
- MixColumns: xtime over GF(2^8), reduction polynomial 0x11b.
- No X propagation from outputs after reset.

Test Plan:
- Reset: hold AES_rst_n=0, toggle the inputs and AES_en -> AES_data_out=0 and AES_data_out_valid=0 throughout.
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, AES_en high for 1 cycle.
  - Response: valid pulses exactly 1 cycle, 10 cycles after capture, with AES_data_out = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Response: out 3925841d02dc09fbdc118597196a0b32. Change AES_data_in and AES_key_in and drop AES_en during BUSY -> result unchanged.
- Continuous enable:
  - Stimulus: all-zero key and pt, AES_en held high for 51 cycles.
  - Response: valid pulses every 11 cycles, each with out 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - After AES_en drops: no further pulses; output held.
- Reset mid-run: assert AES_rst_n=0 at round 5 -> no valid pulse, out=0. A fresh start after release gives the correct ciphertext.
- Idle stability: AES_en=0 with random data/key changes for 100 cycles -> no valid pulse, AES_data_out unchanged from the last result.
